// File: rtl/coh_pkg.sv
// rtl/coh_pkg.sv - shared coherence message, opcode and line-state definitions
// Imported by the L1 controller and its line store; the line-state codes match
// the directory's DI/DS/DM encoding so both ends agree on the meaning of a state.
package coh_pkg;

  localparam int MSG_W    = 22;
  localparam int OP_LSB   = 16;
  localparam int ADDR_LSB = 13;
  localparam int NODE_POS = 12;

  localparam logic [MSG_W-1:0] IDLE_MSG = 22'h3FFFFF;

  localparam logic [2:0] OP_READ_MISS  = 3'b000;
  localparam logic [2:0] OP_WRITE_MISS = 3'b001;
  localparam logic [2:0] OP_UPGRADE    = 3'b010;
  localparam logic [2:0] OP_WRITE_BACK = 3'b011;
  localparam logic [2:0] OP_DATA_REPLY = 3'b100;
  localparam logic [2:0] OP_INV_REQ    = 3'b101;
  localparam logic [2:0] OP_FETCH      = 3'b110;
  localparam logic [2:0] OP_FETCH_INV  = 3'b111;

  localparam logic [1:0] DI = 2'b00;
  localparam logic [1:0] DS = 2'b01;
  localparam logic [1:0] DM = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_VICTIM,
    ST_SEND_REQ,
    ST_WAIT_REPLY,
    ST_RESP
  } l1_state_t;

  function automatic logic [MSG_W-1:0] make_msg(input logic [2:0] op, input logic [2:0] addr,
                                                input logic node, input logic [11:0] data);
    return {3'b000, op, addr, node, data};
  endfunction

endpackage

// File: rtl/l1_line_store.sv
// rtl/l1_line_store.sv - direct-mapped tag/state/data array for the L1 controller
// Ports:
//   clock, reset                  : clock, synchronous active-high reset (all lines to DI)
//   rd_idx -> rd_tag/state/data   : combinational read port for the FSM
//   wr_en/wr_idx/wr_tag/state/data: full-line write port for the FSM
//   snp_idx -> snp_tag/state/data : combinational lookup for incoming snoops
//   snp_upd/snp_new_state         : state-only update from the snoop path
module l1_line_store
  import coh_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  rd_idx,
  output logic        rd_tag,
  output logic [1:0]  rd_state,
  output logic [11:0] rd_data,
  input  logic        wr_en,
  input  logic [1:0]  wr_idx,
  input  logic        wr_tag,
  input  logic [1:0]  wr_state,
  input  logic [11:0] wr_data,
  input  logic [1:0]  snp_idx,
  output logic        snp_tag,
  output logic [1:0]  snp_state,
  output logic [11:0] snp_data,
  input  logic        snp_upd,
  input  logic [1:0]  snp_new_state
);

  logic        tag_q   [LINES];
  logic [1:0]  state_q [LINES];
  logic [11:0] data_q  [LINES];

  assign rd_tag    = tag_q[rd_idx];
  assign rd_state  = state_q[rd_idx];
  assign rd_data   = data_q[rd_idx];
  assign snp_tag   = tag_q[snp_idx];
  assign snp_state = state_q[snp_idx];
  assign snp_data  = data_q[snp_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]   <= 1'b0;
        state_q[i] <= DI;
        data_q[i]  <= 12'h000;
      end
    end else begin
      if (wr_en) begin
        tag_q[wr_idx]   <= wr_tag;
        state_q[wr_idx] <= wr_state;
        data_q[wr_idx]  <= wr_data;
      end
      // A snoop reflects the directory's view of the line, so its state
      // update wins over an FSM write to the same line in the same cycle.
      if (snp_upd) begin
        state_q[snp_idx] <= snp_new_state;
      end
    end
  end

endmodule

// File: rtl/l1_coherence_ctrl.sv
// rtl/l1_coherence_ctrl.sv - private L1 cache coherence controller for one CPU node
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   cpu_req_valid/write/addr/wdata, cpu_req_ready : CPU load/store request handshake
//   cpu_resp_valid, cpu_resp_rdata                : one-cycle completion pulse with line data
//   bus_req, bus_grant       : common-bus arbitration
//   bus_out, bus_in          : outgoing / incoming coherence messages, all-ones when idle
module l1_coherence_ctrl
  import coh_pkg::*;
#(
  parameter int NODE_ID = 0,
  parameter int LINES   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req_valid,
  input  logic        cpu_req_write,
  input  logic [2:0]  cpu_req_addr,
  input  logic [11:0] cpu_req_wdata,
  output logic        cpu_req_ready,
  output logic        cpu_resp_valid,
  output logic [11:0] cpu_resp_rdata,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [21:0] bus_out,
  input  logic [21:0] bus_in
);

  localparam logic NODE_BIT = 1'(NODE_ID);

  l1_state_t   state;
  logic [2:0]  pend_addr;
  logic        pend_write;
  logic        pend_upgrade;
  logic [11:0] pend_wdata;
  logic        snp_valid;
  logic [21:0] snp_msg;

  logic [1:0]  rd_idx;
  logic        rd_tag;
  logic [1:0]  rd_state;
  logic [11:0] rd_data;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic        wr_tag;
  logic [1:0]  wr_state;
  logic [11:0] wr_data;
  logic        snp_tag;
  logic [1:0]  snp_state;
  logic [11:0] snp_data;
  logic        snp_upd;
  logic [1:0]  snp_new_state;

  logic [2:0]  in_op;
  logic [2:0]  in_addr;
  logic [2:0]  req_op;
  logic        for_me, accept, hit, fast_hit, granted, drain, fsm_grant;
  logic        reply, snp_match, new_fetch;

  assign in_op   = bus_in[OP_LSB +: 3];
  assign in_addr = bus_in[ADDR_LSB +: 3];

  l1_line_store #(.LINES(LINES)) u_store (
    .clock         (clock),
    .reset         (reset),
    .rd_idx        (rd_idx),
    .rd_tag        (rd_tag),
    .rd_state      (rd_state),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .wr_tag        (wr_tag),
    .wr_state      (wr_state),
    .wr_data       (wr_data),
    .snp_idx       (in_addr[1:0]),
    .snp_tag       (snp_tag),
    .snp_state     (snp_state),
    .snp_data      (snp_data),
    .snp_upd       (snp_upd),
    .snp_new_state (snp_new_state)
  );

  always_comb begin
    for_me    = (bus_in != IDLE_MSG) && (bus_in[NODE_POS] == NODE_BIT);
    accept    = (state == ST_IDLE) && cpu_req_ready && cpu_req_valid;
    // In IDLE the read port looks up the incoming request; afterwards it
    // tracks the pending line (which is also the victim slot).
    rd_idx    = (state == ST_IDLE) ? cpu_req_addr[1:0] : pend_addr[1:0];
    hit       = (rd_state != DI) && (rd_tag == cpu_req_addr[2]);
    fast_hit  = hit && (!cpu_req_write || rd_state == DM);
    granted   = bus_req && bus_grant;
    drain     = granted && snp_valid;
    fsm_grant = granted && !snp_valid;
    reply     = (state == ST_WAIT_REPLY) && for_me && (in_op == OP_DATA_REPLY) &&
                (in_addr == pend_addr);
    snp_match = for_me && (snp_state != DI) && (snp_tag == in_addr[2]);
    // A fetch is only honoured when the writeback buffer is free.
    new_fetch = snp_match && (snp_state == DM) && !snp_valid &&
                ((in_op == OP_FETCH) || (in_op == OP_FETCH_INV));
    snp_upd   = (snp_match && (in_op == OP_INV_REQ)) || new_fetch;
    snp_new_state = (in_op == OP_FETCH) ? DS : DI;
    req_op    = pend_upgrade ? OP_UPGRADE : (pend_write ? OP_WRITE_MISS : OP_READ_MISS);

    wr_en    = 1'b0;
    wr_idx   = rd_idx;
    wr_tag   = rd_tag;
    wr_state = DI;
    wr_data  = rd_data;
    if (accept && cpu_req_write && fast_hit) begin
      wr_en    = 1'b1;
      wr_state = DM;
      wr_data  = cpu_req_wdata;
    end else if (accept && !hit && rd_state == DS) begin
      wr_en = 1'b1;                       // clean victim dropped silently
    end else if (state == ST_WB_VICTIM && fsm_grant) begin
      wr_en = 1'b1;                       // dirty victim leaves once written back
    end else if (reply) begin
      // A store (miss or upgrade, even if invalidated meanwhile) ends with
      // the whole word replaced by the store data, so the reply is not needed.
      wr_en    = 1'b1;
      wr_tag   = pend_addr[2];
      wr_state = pend_write ? DM : DS;
      wr_data  = pend_write ? pend_wdata : bus_in[11:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      cpu_req_ready  <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= 12'h000;
      bus_req        <= 1'b0;
      bus_out        <= IDLE_MSG;
      snp_valid      <= 1'b0;
      snp_msg        <= IDLE_MSG;
      pend_addr      <= 3'd0;
      pend_write     <= 1'b0;
      pend_upgrade   <= 1'b0;
      pend_wdata     <= 12'h000;
    end else begin
      cpu_resp_valid <= 1'b0;
      bus_out        <= drain ? snp_msg : IDLE_MSG;
      cpu_req_ready  <= ((state == ST_IDLE) && !accept) || (state == ST_RESP);
      // Drop the request for one cycle after every grant, then re-request
      // if the buffer or the FSM still has something to send.
      bus_req <= !granted && (snp_valid || new_fetch || state == ST_WB_VICTIM ||
                              state == ST_SEND_REQ || (accept && !fast_hit));
      if (new_fetch) begin
        snp_valid <= 1'b1;
        snp_msg   <= make_msg(OP_WRITE_BACK, in_addr, NODE_BIT, snp_data);
      end else if (drain) begin
        snp_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            pend_addr    <= cpu_req_addr;
            pend_write   <= cpu_req_write;
            pend_wdata   <= cpu_req_wdata;
            pend_upgrade <= cpu_req_write && hit && (rd_state == DS);
            if (fast_hit)            state <= ST_RESP;
            else if (hit)            state <= ST_SEND_REQ;
            else if (rd_state == DM) state <= ST_WB_VICTIM;
            else                     state <= ST_SEND_REQ;
          end
        end
        ST_WB_VICTIM: begin
          if (fsm_grant) begin
            bus_out <= make_msg(OP_WRITE_BACK, {rd_tag, pend_addr[1:0]}, NODE_BIT, rd_data);
            state   <= ST_SEND_REQ;
          end
        end
        ST_SEND_REQ: begin
          if (fsm_grant) begin
            bus_out <= make_msg(req_op, pend_addr, NODE_BIT, 12'h000);
            state   <= ST_WAIT_REPLY;
          end
        end
        ST_WAIT_REPLY: begin
          if (reply) state <= ST_RESP;
        end
        ST_RESP: begin
          cpu_resp_valid <= 1'b1;
          cpu_resp_rdata <= rd_data;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/l1_coherence_ctrl.md
Name: l1_coherence_ctrl

Overview:
Per-processor private-cache controller, one instance per CPU node. It is the upstream source and downstream consumer of the directory.
- Converts CPU load/store requests into coherence messages on the common bus.
- Consumes directory replies and directory-originated invalidate/fetch commands.
- Holds a direct-mapped 4-line cache with I/S/M line states.

Parameters:
NODE_ID, 0, node number carried in message bit [12]; only 0 or 1 legal.
LINES, 4, cache lines; index = addr[1:0], stored tag bit = addr[2].

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
cpu_req_valid  in  1  CPU request present
cpu_req_write  in  1  1=store, 0=load
cpu_req_addr  in  3  block address (directory tag)
cpu_req_wdata  in  12  store data
cpu_req_ready  out  1  request accepted this cycle when valid&ready
cpu_resp_valid  out  1  one-cycle completion pulse
cpu_resp_rdata  out  12  load data (store: written value)
bus_req  out  1  requesting common bus
bus_grant  in  1  bus granted this cycle
bus_out  out  22  outgoing message; all-ones when idle
bus_in  in  22  directory message; all-ones = idle

Behaviour:
Message format (22 bits):
- [21:19]=000, [18:16]=opcode, [15:13]=block address, [12]=node id, [11:0]=data.
- Opcodes: 000 READ_MISS, 001 WRITE_MISS, 010 UPGRADE, 011 WRITE_BACK, 100 DATA_REPLY, 101 INV_REQ, 110 FETCH, 111 FETCH_INV.
- Messages addressed to this node: bus_in != all-ones and bus_in[12]==NODE_ID; all others ignored.

Line states and reset:
- Line states: I=00, S=01, M=10.
- Reset: all lines I; FSM IDLE; cpu_req_ready=0, cpu_resp_valid=0, cpu_resp_rdata=0, bus_req=0, bus_out=all-ones.
- Reset asserted mid-operation abandons any pending transaction; no message is emitted that cycle.

FSM states: IDLE, WB_VICTIM, SEND_REQ, WAIT_REPLY, RESP.
- IDLE: cpu_req_ready=1; request captured on valid&ready.
  - Load hit (S/M, tag match) or store hit in M: next state RESP. Store hit also writes data. Latency 2 cycles accept->resp_valid.
  - Store hit in S: opcode=UPGRADE -> SEND_REQ.
  - Miss with victim in M -> WB_VICTIM. Miss with victim in I/S: S victim silently dropped to I -> SEND_REQ.
- WB_VICTIM: bus_req=1; on grant emit WRITE_BACK {victim addr, NODE_ID, victim data}; victim -> I; -> SEND_REQ.
- SEND_REQ: bus_req=1; on grant emit READ_MISS (load), WRITE_MISS (store miss) or UPGRADE, data=0; -> WAIT_REPLY.
- WAIT_REPLY: waits, unbounded, for DATA_REPLY whose [15:13] equals the pending address.
  - Load: fill line with data [11:0], state S.
  - Store: fill line, then overwrite with store data, state M.
  - UPGRADE: reply data ignored; state M; store data written.
  - Then -> RESP.
- RESP: cpu_resp_valid=1 for exactly one cycle with line data -> IDLE.

Snoop handling (any FSM state, same cycle as arrival):
- INV_REQ with tag match: line -> I.
- FETCH with line in M: line -> S; WRITE_BACK queued.
- FETCH_INV with line in M: line -> I; WRITE_BACK queued.
- FETCH/FETCH_INV on a non-M or mismatched line: ignored.
- Single-entry snoop-writeback buffer. It has priority for the bus over WB_VICTIM/SEND_REQ; FSM stalls in place while it drains.
- A second fetch arriving while the buffer is full is a protocol error; it is not stored, and the bench checks it never occurs.

Simultaneous events:
- INV_REQ to the pending line while in WAIT_REPLY for UPGRADE: the line is already I. On reply, treat as store miss fill (data from reply, then store data), state M.
- DATA_REPLY and a snoop to a different line in the same cycle: both applied.
- bus_out is non-idle for exactly one cycle per grant; bus_req deasserts the cycle after the grant.

Decomposition:
- Shared package coh_pkg: opcode constants, line-state constants (shared with directory encoding DI/DS/DM), IDLE_MSG=22'h3FFFFF, message field positions.
- Natural sub-module: l1_line_store (4-entry tag/state/data array, one read port, one write port, separate snoop update port).

Test Plan:
1. After reset, load addr 3 -> bus_out READ_MISS {op 000, addr 011, node NODE_ID}. Then bus_in DATA_REPLY data 12'h018 -> cpu_resp_valid with rdata 12'h018; line 3 in S.
2. Store addr 3 data 12'h055 with line in S -> UPGRADE emitted. Then DATA_REPLY -> line M; a later load of addr 3 hits, resp 12'h055 two cycles after accept, no bus traffic.
3. Line 0 in M (addr 0, data 12'h00A); load addr 4 -> WRITE_BACK {addr 000, data 00A} first, then READ_MISS addr 100.
4. Line in M; bus_in FETCH_INV to it while an unrelated miss sits in SEND_REQ -> snoop WRITE_BACK wins the next grant; line I; the miss follows.
5. INV_REQ during UPGRADE wait -> final line state M with store data, not reply data.
6. Assert reset in WAIT_REPLY -> all outputs at reset values next cycle; a later DATA_REPLY is ignored and no resp pulse occurs.
